pmt_pulse_emulator: RTL and testbench

Synthetic photomultiplier pulse source for bench and in-system testing of the photon-counting lock-in path. It generates pseudo-random single-photon pulses on `pulse_out`. The arrival probability per clock is selected by the current state of the light-modulation reference, so the counting logic sees a known, phase-correlated signal. Its output drives the PMT input in place of the real tube, with programmable pulse width, dead time and dark rate.

---
 rtl/pmt_pulse_emulator.sv | 159 +++++++++++++++
 tb/tb_pmt_pulse_emulator.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pmt_pulse_emulator.sv
// pmt_pulse_emulator
// Synthetic photomultiplier pulse source for exercising the photon-counting
// lock-in path. A free-running 32-bit Galois LFSR is compared against a
// per-cycle threshold, chosen by the light-modulation reference, to decide
// when a single-photon pulse starts. Each pulse is PULSE_WIDTH cycles high,
// then DEAD_TIME cycles of forced low.
//
// Optional feature: define PMT_EMU_AFTERPULSE_EN to emulate tube
// afterpulsing. A primary pulse may then be followed by one afterpulse,
// launched in the first IDLE slot after its dead time, with probability
// set by AFTERPULSE_THRESH. Without the macro AFTERPULSE_THRESH is unused.

module pmt_pulse_emulator #(
   parameter logic [31:0] LFSR_SEED         = 32'hACE1_1234,
   parameter int unsigned PULSE_WIDTH       = 5,
   parameter int unsigned DEAD_TIME         = 10,
   parameter logic [7:0]  AFTERPULSE_THRESH = 8'h10
) (
   input  logic        main_clock,
   input  logic        reset,
   input  logic        enable,
   input  logic        light_source_flag,
   input  logic [15:0] rate_on,
   input  logic [15:0] rate_off,
   output logic        pulse_out,
   output logic [31:0] pulse_count,
   output logic        busy
);

   // An all-zero seed would lock the LFSR, so it is replaced by 1.
   localparam logic [31:0] SEED_EFF   = (LFSR_SEED == 32'h0) ? 32'h1 : LFSR_SEED;
   localparam logic [31:0] TAP_MASK   = 32'h8020_0003;
   localparam logic [31:0] WIDTH_LOAD = 32'(PULSE_WIDTH - 1);
   localparam logic [31:0] DEAD_LOAD  = (DEAD_TIME > 0) ? 32'(DEAD_TIME - 1) : 32'h0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PULSE = 2'd1,
      DEAD  = 2'd2
   } state_t;

   state_t      state;
   logic [31:0] lfsr;
   logic [31:0] cnt;
   logic [15:0] thr;
   logic        fire_primary;
   logic        fire_after;
   logic        fire;

`ifdef PMT_EMU_AFTERPULSE_EN
   logic        after_armed;
   logic        is_after;
`endif

   // Free-running Galois LFSR, shifting right; it never pauses for state or enable.
   always_ff @(posedge main_clock or posedge reset) begin
      if (reset) begin
         lfsr <= SEED_EFF;
      end else if (lfsr[0]) begin
         lfsr <= {1'b0, lfsr[31:1]} ^ TAP_MASK;
      end else begin
         lfsr <= {1'b0, lfsr[31:1]};
      end
   end

   // Decide in IDLE whether a primary pulse (or a pending afterpulse) starts this cycle.
   always_comb begin
      thr          = light_source_flag ? rate_on : rate_off;
      fire_primary = 1'b0;
      fire_after   = 1'b0;
      if (state == IDLE && enable) begin
         if (thr == 16'hFFFF) begin
            fire_primary = 1'b1;
         end else if (lfsr[15:0] < thr) begin
            fire_primary = 1'b1;
         end
      end
`ifdef PMT_EMU_AFTERPULSE_EN
      if (state == IDLE && after_armed) begin
         if (AFTERPULSE_THRESH == 8'hFF) begin
            fire_after = 1'b1;
         end else if (lfsr[31:24] < AFTERPULSE_THRESH) begin
            fire_after = 1'b1;
         end
      end
`endif
      fire = fire_primary | fire_after;
   end

   // Pulse sequencer: IDLE -> PULSE (width count) -> DEAD (dead count) -> IDLE, all outputs registered.
   always_ff @(posedge main_clock or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= 32'h0;
         pulse_out   <= 1'b0;
         busy        <= 1'b0;
         pulse_count <= 32'h0;
`ifdef PMT_EMU_AFTERPULSE_EN
         after_armed <= 1'b0;
         is_after    <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
`ifdef PMT_EMU_AFTERPULSE_EN
               // The afterpulse chance exists only in the first IDLE slot after a primary.
               after_armed <= 1'b0;
`endif
               if (fire) begin
                  state     <= PULSE;
                  cnt       <= WIDTH_LOAD;
                  pulse_out <= 1'b1;
                  busy      <= 1'b1;
                  if (pulse_count != 32'hFFFF_FFFF) begin
                     pulse_count <= pulse_count + 32'd1;
                  end
`ifdef PMT_EMU_AFTERPULSE_EN
                  is_after <= fire_after;
`endif
               end
            end
            PULSE: begin
               if (cnt == 32'h0) begin
                  pulse_out <= 1'b0;
                  if (DEAD_TIME == 0) begin
                     state <= IDLE;
                     busy  <= 1'b0;
`ifdef PMT_EMU_AFTERPULSE_EN
                     after_armed <= ~is_after;
`endif
                  end else begin
                     state <= DEAD;
                     cnt   <= DEAD_LOAD;
                  end
               end else begin
                  cnt <= cnt - 32'd1;
               end
            end
            DEAD: begin
               if (cnt == 32'h0) begin
                  state <= IDLE;
                  busy  <= 1'b0;
`ifdef PMT_EMU_AFTERPULSE_EN
                  after_armed <= ~is_after;
`endif
               end else begin
                  cnt <= cnt - 32'd1;
               end
            end
            default: begin
               state     <= IDLE;
               pulse_out <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pmt_pulse_emulator.sv
// tb_pmt_pulse_emulator
// Directed bench for pmt_pulse_emulator. A schedule-based model (fire time,
// next free decision slot) predicts pulse_out, busy and pulse_count every
// cycle; directed scenarios add hand-computed literal expectations.

module tb_pmt_pulse_emulator;

   localparam int          W    = 5;
   localparam int          D    = 10;
   localparam logic [31:0] SEED = 32'hACE1_1234;
   localparam logic [7:0]  APT  = 8'hFF;

   logic        main_clock = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic        light_source_flag = 1'b0;
   logic [15:0] rate_on = 16'h0;
   logic [15:0] rate_off = 16'h0;
   logic        pulse_out;
   logic [31:0] pulse_count;
   logic        busy;

   int vectors = 0;
   int miscompares = 0;
   int cur_cyc = 0;

   int run1[$];
   int run2[$];
   int rises_q[$];

   pmt_pulse_emulator #(
      .LFSR_SEED(SEED),
      .PULSE_WIDTH(W),
      .DEAD_TIME(D),
      .AFTERPULSE_THRESH(APT)
   ) dut (
      .main_clock(main_clock),
      .reset(reset),
      .enable(enable),
      .light_source_flag(light_source_flag),
      .rate_on(rate_on),
      .rate_off(rate_off),
      .pulse_out(pulse_out),
      .pulse_count(pulse_count),
      .busy(busy)
   );

   // Free-running clock, 10 time units per cycle
   always #5 main_clock = ~main_clock;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d, t=%0t)", name, actual, expected, cur_cyc, $time);
      end
   endtask

   task automatic applyStimulus(input logic en, input logic flag, input logic [15:0] ron, input logic [15:0] roff);
      enable            = en;
      light_source_flag = flag;
      rate_on           = ron;
      rate_off          = roff;
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge main_clock);
         #2;
         cur_cyc++;
      end
   endtask

   task automatic doReset();
      @(posedge main_clock);
      #2;
      reset = 1'b1;
      repeat (2) @(posedge main_clock);
      #2;
      checkOutput("reset pulse_out", {31'h0, pulse_out}, 32'h0);
      checkOutput("reset busy", {31'h0, busy}, 32'h0);
      checkOutput("reset pulse_count", pulse_count, 32'h0);
      reset   = 1'b0;
      cur_cyc = 0;
   endtask

   // ---------------- behavioural model ----------------
   // A pulse fired in cycle t is high over t+1..t+W and busy over t+1..t+W+D;
   // the next decision slot is t+W+D+1.
   int          m_cyc;
   int          m_last_fire;
   int          m_next_free;
   bit          m_last_primary;
   bit          m_fired;
   logic [31:0] m_lfsr;
   logic [31:0] m_count;
   logic [15:0] m_thr;
   int          m_d;
   logic        m_exp_pulse;
   logic        m_exp_busy;

   // Per-cycle compare against the model, then advance the model by one cycle
   always @(negedge main_clock) begin
      if (reset) begin
         m_cyc          = 0;
         m_last_fire    = -100000;
         m_next_free    = 0;
         m_last_primary = 1'b0;
         m_count        = 32'h0;
         m_lfsr         = (SEED == 32'h0) ? 32'h1 : SEED;
         checkOutput("model reset pulse_out", {31'h0, pulse_out}, 32'h0);
         checkOutput("model reset pulse_count", pulse_count, 32'h0);
      end else begin
         m_d         = m_cyc - m_last_fire;
         m_exp_pulse = (m_d >= 1) && (m_d <= W);
         m_exp_busy  = (m_cyc > m_last_fire) && (m_cyc < m_next_free);
         checkOutput("model pulse_out", {31'h0, pulse_out}, {31'h0, m_exp_pulse});
         checkOutput("model busy", {31'h0, busy}, {31'h0, m_exp_busy});
         checkOutput("model pulse_count", pulse_count, m_count);
         if (m_cyc >= m_next_free) begin
            m_fired = 1'b0;
`ifdef PMT_EMU_AFTERPULSE_EN
            if (m_cyc == m_next_free && m_last_primary &&
                (APT == 8'hFF || m_lfsr[31:24] < APT)) begin
               m_last_fire    = m_cyc;
               m_next_free    = m_cyc + W + D + 1;
               m_last_primary = 1'b0;
               m_fired        = 1'b1;
               if (m_count != 32'hFFFF_FFFF) m_count = m_count + 1;
            end
`endif
            m_thr = light_source_flag ? rate_on : rate_off;
            if (!m_fired && enable && (m_thr == 16'hFFFF || m_lfsr[15:0] < m_thr)) begin
               m_last_fire    = m_cyc;
               m_next_free    = m_cyc + W + D + 1;
               m_last_primary = 1'b1;
               if (m_count != 32'hFFFF_FFFF) m_count = m_count + 1;
            end
         end
         m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 32'h8020_0003) : (m_lfsr >> 1);
         m_cyc++;
      end
   end

   // Hard time limit so the run can never hang
   initial begin
      #5000000;
      $display("[TB] FAIL watchdog: time limit reached, got running, expected finished");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed scenarios
   initial begin
      int highs;
      int rises;
      bit prev_flag;
      bit prev_busy;
      bit prev_pulse;
      bit found;
      int n;

      // ---- Continuous fire: period 16, 5 high ----
      $display("[TB] continuous fire");
      applyStimulus(1'b1, 1'b0, 16'hFFFF, 16'hFFFF);
      doReset();
      highs = 0;
      for (int k = 1; k <= 170; k++) begin
         step(1);
         if (pulse_out && cur_cyc <= 160) highs++;
         if (cur_cyc == 1)   checkOutput("cont first high", {31'h0, pulse_out}, 32'h1);
         if (cur_cyc == 5)   checkOutput("cont last high", {31'h0, pulse_out}, 32'h1);
         if (cur_cyc == 6)   checkOutput("cont dead low", {31'h0, pulse_out}, 32'h0);
         if (cur_cyc == 15)  checkOutput("cont busy end dead", {31'h0, busy}, 32'h1);
         if (cur_cyc == 16)  checkOutput("cont idle busy", {31'h0, busy}, 32'h0);
         if (cur_cyc == 17)  checkOutput("cont second rise", {31'h0, pulse_out}, 32'h1);
         if (cur_cyc == 160) checkOutput("cont count 10", pulse_count, 32'd10);
         if (cur_cyc == 161) checkOutput("cont count 11", pulse_count, 32'd11);
      end
      checkOutput("cont high cycles", highs, 32'd50);

      // ---- Zero rate: nothing ever fires ----
      $display("[TB] zero rate");
      applyStimulus(1'b1, 1'b0, 16'h0, 16'h0);
      doReset();
      highs = 0;
      for (int k = 0; k < 10000; k++) begin
         step(1);
         if (pulse_out) highs++;
      end
      checkOutput("zero high cycles", highs, 32'd0);
      checkOutput("zero pulse_count", pulse_count, 32'd0);
      checkOutput("zero busy", {31'h0, busy}, 32'h0);

      // ---- Modulation correlation: flag toggles every 250 cycles ----
      $display("[TB] modulation correlation");
      applyStimulus(1'b1, 1'b0, 16'hFFFF, 16'h0);
      doReset();
      rises = 0; prev_flag = 1'b0; prev_busy = 1'b0; prev_pulse = 1'b0;
      for (int k = 0; k < 1000; k++) begin
         if (k > 0) step(1);
         if (pulse_out && !prev_pulse) begin
            rises++;
            checkOutput("mod rise after lit idle", {30'h0, prev_flag, prev_busy}, 32'h2);
         end
         light_source_flag = ((k / 250) % 2) == 1;
         prev_flag  = light_source_flag;
         prev_busy  = busy;
         prev_pulse = pulse_out;
      end
      checkOutput("mod rise count", rises, 32'd32);
      checkOutput("mod pulse_count", pulse_count, 32'd32);

      // ---- Enable dropped in the 2nd high cycle ----
      $display("[TB] enable drop mid-pulse");
      applyStimulus(1'b1, 1'b0, 16'hFFFF, 16'hFFFF);
      doReset();
      step(2);
      enable = 1'b0;
      highs = 0;
      for (int k = 3; k <= 120; k++) begin
         step(1);
         if (pulse_out) highs++;
         if (cur_cyc == 5)  checkOutput("drop still high", {31'h0, pulse_out}, 32'h1);
         if (cur_cyc == 6)  checkOutput("drop dead low", {31'h0, pulse_out}, 32'h0);
         if (cur_cyc == 15) checkOutput("drop busy in dead", {31'h0, busy}, 32'h1);
         if (cur_cyc == 16) checkOutput("drop busy falls", {31'h0, busy}, 32'h0);
      end
      checkOutput("drop remaining highs", highs, 32'd3);
      checkOutput("drop pulse_count", pulse_count, 32'd1);

      // ---- Reset mid-pulse, then replay matches power-on run ----
      $display("[TB] reset mid-pulse");
      applyStimulus(1'b1, 1'b0, 16'h6000, 16'h6000);
      doReset();
      run1.delete();
      prev_pulse = 1'b0;
      for (int k = 0; k <= 80; k++) begin
         if (k > 0) step(1);
         if (pulse_out && !prev_pulse) run1.push_back(cur_cyc);
         prev_pulse = pulse_out;
      end
      checkOutput("power-on run has pulses", {31'h0, run1.size() > 0}, 32'h1);
      found = 1'b0; highs = 0;
      for (int k = 0; k < 300 && !found; k++) begin
         step(1);
         if (pulse_out && !prev_pulse) highs = 1;
         else if (pulse_out && highs > 0) highs++;
         else highs = 0;
         prev_pulse = pulse_out;
         if (highs == 3) found = 1'b1;
      end
      checkOutput("reach 3rd high cycle", {31'h0, found}, 32'h1);
      reset = 1'b1;
      #1;
      checkOutput("async reset pulse_out", {31'h0, pulse_out}, 32'h0);
      checkOutput("async reset pulse_count", pulse_count, 32'h0);
      checkOutput("async reset busy", {31'h0, busy}, 32'h0);
      repeat (2) @(posedge main_clock);
      #2;
      reset   = 1'b0;
      cur_cyc = 0;
      run2.delete();
      prev_pulse = 1'b0;
      for (int k = 0; k <= 80; k++) begin
         if (k > 0) step(1);
         if (pulse_out && !prev_pulse) run2.push_back(cur_cyc);
         prev_pulse = pulse_out;
      end
      checkOutput("replay pulse total", run2.size(), run1.size());
      n = (run1.size() < run2.size()) ? run1.size() : run2.size();
      for (int i = 0; i < n; i++) begin
         checkOutput("replay rise time", run2[i], run1[i]);
      end

      // ---- Enable for one IDLE cycle only: afterpulse behaviour ----
      $display("[TB] single-cycle enable");
      applyStimulus(1'b1, 1'b0, 16'hFFFF, 16'hFFFF);
      doReset();
      rises_q.delete();
      prev_pulse = 1'b0;
      for (int k = 1; k <= 60; k++) begin
         step(1);
         if (cur_cyc == 1) enable = 1'b0;
         if (pulse_out && !prev_pulse) rises_q.push_back(cur_cyc);
         prev_pulse = pulse_out;
      end
      if (rises_q.size() > 0) checkOutput("single first rise", rises_q[0], 32'd1);
`ifdef PMT_EMU_AFTERPULSE_EN
      checkOutput("afterpulse rise total", rises_q.size(), 32'd2);
      if (rises_q.size() > 1) checkOutput("afterpulse rise spacing", rises_q[1] - rises_q[0], 32'd16);
      checkOutput("afterpulse pulse_count", pulse_count, 32'd2);
`else
      checkOutput("single rise total", rises_q.size(), 32'd1);
      checkOutput("single pulse_count", pulse_count, 32'd1);
`endif

      step(2);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
